// File: rtl/ce_startup_sequencer.sv
// ce_startup_sequencer
// Releases the clock enables of STAGES downstream domains one at a time.
// Each stage waits STAGE_DELAY CE-high cycles and is then enabled. The next
// stage starts only after the enabled stage acknowledges ready. A stage that
// stays silent for ACK_TIMEOUT CE-high cycles latches a fault. A fault gates
// every CE output off.
module ce_startup_sequencer #(
   parameter int STAGES      = 4,
   parameter int STAGE_DELAY = 16,
   parameter int ACK_TIMEOUT = 64
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              CE,
   input  logic              RESTART,
   input  logic [STAGES-1:0] STAGE_ACK,
   output logic [STAGES-1:0] CE_OUT,
   output logic              BUSY,
   output logic              DONE,
   output logic              FAULT,
   output logic [3:0]        FAULT_STAGE
);

   // The counter is sized for the larger of the two limits and is at least 1 bit wide.
   localparam int MAX_LIM = (STAGE_DELAY > ACK_TIMEOUT) ? STAGE_DELAY : ACK_TIMEOUT;
   localparam int CNT_W   = (MAX_LIM < 1) ? 1 : $clog2(MAX_LIM + 1);

   // Terminal counts. A limit of 0 never reaches its terminal compare.
   localparam logic [CNT_W-1:0]  DLY_LAST  = CNT_W'((STAGE_DELAY > 0) ? STAGE_DELAY - 1 : 0);
   localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
   localparam logic [3:0]        LAST_IDX  = 4'(STAGES - 1);
   localparam logic [STAGES-1:0] STAGE_ONE = STAGES'(1);

   typedef enum logic [1:0] {
      S_DELAY,
      S_ACK,
      S_RUN,
      S_FAULT
   } state_t;

   state_t             state;
   logic [3:0]         idx;
   logic [CNT_W-1:0]   cnt;
   logic [STAGES-1:0]  en;
   logic [3:0]         fault_stage;
   logic               busy_q;
   logic               done_q;
   logic               fault_q;

   // One-hot select of the active stage. Only that stage's ACK is observed.
   logic [STAGES-1:0]  idx_bit;
   logic               ack_hit;

   assign idx_bit = STAGE_ONE << idx;
   assign ack_hit = |(STAGE_ACK & idx_bit);

   // Sequencer FSM. Status flags are registered next to the state, so they switch on the same edge.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state       <= S_DELAY;
         idx         <= '0;
         cnt         <= '0;
         en          <= '0;
         fault_stage <= '0;
         busy_q      <= 1'b1;
         done_q      <= 1'b0;
         fault_q     <= 1'b0;
      end else if (RESTART) begin
         state       <= S_DELAY;
         idx         <= '0;
         cnt         <= '0;
         en          <= '0;
         fault_stage <= '0;
         busy_q      <= 1'b1;
         done_q      <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here, so every branch reads the values from before the edge.
         unique case (state)
            S_DELAY: begin
               // A zero delay enables the stage on the next clock, whatever the value of CE.
               if (STAGE_DELAY == 0 || (CE && cnt == DLY_LAST)) begin
                  en    <= en | idx_bit;
                  cnt   <= '0;
                  state <= S_ACK;
               end else if (CE) begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_ACK: begin
               // ACK is checked before the timeout, so an ACK on the final cycle still wins.
               if (ack_hit) begin
                  cnt <= '0;
                  if (idx == LAST_IDX) begin
                     state  <= S_RUN;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= S_DELAY;
                  end
               end else if (CE && ACK_TIMEOUT != 0) begin
                  if (cnt == TMO_LAST) begin
                     en          <= '0;
                     fault_stage <= idx;
                     cnt         <= '0;
                     state       <= S_FAULT;
                     busy_q      <= 1'b0;
                     fault_q     <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            S_RUN, S_FAULT: begin
               // Terminal states. Only RESTART or reset leaves them.
            end
         endcase
      end
   end

   // NOTE: CE_OUT is a plain AND with the registered enables, so it follows CE without a cycle of lag.
   assign CE_OUT      = {STAGES{CE}} & en;
   assign BUSY        = busy_q;
   assign DONE        = done_q;
   assign FAULT       = fault_q;
   assign FAULT_STAGE = fault_stage;

endmodule

// File: tb/tb_ce_startup_sequencer.sv
// Testbench for ce_startup_sequencer. Two instances are driven: the default
// one (delay 16, timeout 64) and a zero-delay one. Each instance is compared
// every cycle against a stage-count model of the bring-up rules.
module tb_ce_startup_sequencer;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ce = 1'b0;
   logic       restart = 1'b0;
   logic [3:0] ack = '0;
   logic [3:0] ce_out;
   logic       busy, done, fault;
   logic [3:0] fault_stage;

   logic       rst0_n = 1'b0;
   logic       ce0 = 1'b0;
   logic       restart0 = 1'b0;
   logic [3:0] ack0 = '0;
   logic [3:0] ce_out0;
   logic       busy0, done0, fault0;
   logic [3:0] fault_stage0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ce_startup_sequencer #(.STAGES(N), .STAGE_DELAY(16), .ACK_TIMEOUT(64)) dut (
      .CLK(clk), .RESET(rst_n), .CE(ce), .RESTART(restart), .STAGE_ACK(ack),
      .CE_OUT(ce_out), .BUSY(busy), .DONE(done), .FAULT(fault), .FAULT_STAGE(fault_stage)
   );

   ce_startup_sequencer #(.STAGES(N), .STAGE_DELAY(0), .ACK_TIMEOUT(64)) dut0 (
      .CLK(clk), .RESET(rst0_n), .CE(ce0), .RESTART(restart0), .STAGE_ACK(ack0),
      .CE_OUT(ce_out0), .BUSY(busy0), .DONE(done0), .FAULT(fault0), .FAULT_STAGE(fault_stage0)
   );

   // Model state: how many stages are enabled, whether the newest stage still owes an ACK,
   // and how many CE-high cycles have been spent in the current wait.
   typedef struct {
      int n_en;
      int cnt;
      bit waiting;
      bit run;
      bit flt;
      int fstage;
   } mdl_t;

   mdl_t m, m0;

   function automatic mdl_t mdl_reset();
      mdl_t r;
      r.n_en = 0; r.cnt = 0; r.waiting = 1'b0; r.run = 1'b0; r.flt = 1'b0; r.fstage = 0;
      return r;
   endfunction

   function automatic mdl_t mdl_step(mdl_t m_in, bit c, bit rs, logic [3:0] a, int dly, int tmo);
      mdl_t r;
      r = m_in;
      if (rs) begin
         r = mdl_reset();
      end else if (m_in.run || m_in.flt) begin
         r = m_in;
      end else if (!m_in.waiting) begin
         if (dly == 0) begin
            r.n_en = m_in.n_en + 1; r.waiting = 1'b1; r.cnt = 0;
         end else if (c) begin
            r.cnt = m_in.cnt + 1;
            if (r.cnt == dly) begin
               r.n_en = m_in.n_en + 1; r.waiting = 1'b1; r.cnt = 0;
            end
         end
      end else begin
         if (a[m_in.n_en-1] === 1'b1) begin
            r.cnt = 0; r.waiting = 1'b0;
            if (m_in.n_en == N) r.run = 1'b1;
         end else if (c) begin
            r.cnt = m_in.cnt + 1;
            if (tmo != 0 && r.cnt == tmo) begin
               r.flt = 1'b1; r.fstage = m_in.n_en - 1; r.cnt = 0; r.waiting = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Expected {CE_OUT, BUSY, DONE, FAULT, FAULT_STAGE} for the model state under the current CE.
   function automatic logic [10:0] exp_outs(mdl_t mm, logic c);
      logic [3:0] en_e;
      logic [3:0] fs;
      en_e = mm.flt ? 4'b0 : 4'((1 << mm.n_en) - 1);
      fs   = mm.flt ? 4'(mm.fstage) : 4'd0;
      return {(c ? en_e : 4'b0), (!mm.run && !mm.flt), mm.run, mm.flt, fs};
   endfunction

   function automatic logic [10:0] outs();
      return {ce_out, busy, done, fault, fault_stage};
   endfunction

   function automatic logic [10:0] outs0();
      return {ce_out0, busy0, done0, fault0, fault_stage0};
   endfunction

   // Reference models advance on the same edges as the DUTs, including the asynchronous reset.
   always @(posedge clk or negedge rst_n)
      if (!rst_n) m <= mdl_reset();
      else        m <= mdl_step(m, ce, restart, ack, 16, 64);

   always @(posedge clk or negedge rst0_n)
      if (!rst0_n) m0 <= mdl_reset();
      else         m0 <= mdl_step(m0, ce0, restart0, ack0, 0, 64);

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; ce = 1'b0; ack = '0; restart = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rst0_n = 1'b0;
      ce = 1'b1; ce0 = 1'b1; ack = '0; ack0 = '0; restart = 1'b0; restart0 = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      if (outs() !== {4'b0, 1'b1, 1'b0, 1'b0, 4'b0}) begin
         errors++; $display("FAIL reset_outs got=%h want=%h", outs(), {4'b0, 1'b1, 1'b0, 1'b0, 4'b0});
      end
      checks++;
      if (outs0() !== {4'b0, 1'b1, 1'b0, 1'b0, 4'b0}) begin
         errors++; $display("FAIL reset_outs_d0 got=%h want=%h", outs0(), {4'b0, 1'b1, 1'b0, 1'b0, 4'b0});
      end
      checks++;
      ce = 1'b0; ce0 = 1'b0;
   endtask

   task automatic test_delay0();
      int s1;
      bit seen;
      @(negedge clk);
      ce0 = 1'b0; rst0_n = 1'b1;
      #1; ce0 = 1'b1; #1;
      if (ce_out0 !== 4'b0000) begin
         errors++; $display("FAIL d0_before_edge got=%b want=0000", ce_out0);
      end
      checks++;
      ce0 = 1'b0;
      @(negedge clk);
      #1; ce0 = 1'b1; #1;
      if (ce_out0 !== 4'b0001) begin
         errors++; $display("FAIL d0_en0_one_clock got=%b want=0001", ce_out0);
      end
      checks++;
      ce0 = 1'b0;
      // CE held low: the ACK timeout must not advance however long the wait lasts.
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         ce0 = 1'b0; ack0 = '0;
         #1;
         if (outs0() !== exp_outs(m0, ce0)) begin
            errors++; $display("FAIL d0_ce_low cyc=%0d got=%h want=%h", i, outs0(), exp_outs(m0, ce0));
         end
         checks++;
      end
      // The ACK is still accepted while CE=0. Then stage 1 times out under CE=1.
      @(negedge clk);
      ack0 = 4'b0001;
      #1;
      if (outs0() !== exp_outs(m0, ce0)) begin
         errors++; $display("FAIL d0_ack0 got=%h want=%h", outs0(), exp_outs(m0, ce0));
      end
      checks++;
      s1 = 0; seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         ce0 = 1'b1;
         if (m0.waiting && m0.n_en == 2) s1++;
         #1;
         if (outs0() !== exp_outs(m0, ce0)) begin
            errors++; $display("FAIL d0_timeout cyc=%0d got=%h want=%h", i, outs0(), exp_outs(m0, ce0));
         end
         checks++;
         if (fault0 === 1'b1) seen = 1'b1;
      end
      if (!(seen && s1 == 64 && fault_stage0 === 4'd1)) begin
         errors++; $display("FAIL d0_fault seen=%0d ce_hi=%0d stage=%0d want 1/64/1", seen, s1, fault_stage0);
      end
      checks++;
      ce0 = 1'b0;
   endtask

   task automatic test_nominal(input string tag);
      int ce_hi, first_hi, wclk;
      logic [3:0] acc;
      logic c;
      bit done_seen;
      do_reset();
      ce_hi = 0; first_hi = 0; wclk = 0; acc = '0; done_seen = 1'b0;
      for (int i = 0; i < 1000 && !done_seen; i++) begin
         @(negedge clk);
         c = (i % 2 == 0);
         if (m.waiting) wclk++; else wclk = 0;
         if (m.waiting && wclk >= 3) acc[m.n_en-1] = 1'b1;
         ce = c; ack = acc;
         #1;
         if (c) begin
            ce_hi++;
            if (first_hi == 0 && ce_out[0] === 1'b1) first_hi = ce_hi;
         end
         if (outs() !== exp_outs(m, c)) begin
            errors++; $display("FAIL %s cyc=%0d got=%h want=%h", tag, i, outs(), exp_outs(m, c));
         end
         checks++;
         if (done === 1'b1) done_seen = 1'b1;
      end
      if (first_hi != 17) begin
         errors++; $display("FAIL %s_en0_rise first_ce_out_cycle=%0d want=17", tag, first_hi);
      end
      checks++;
      if (!(done === 1'b1 && busy === 1'b0)) begin
         errors++; $display("FAIL %s_done done=%b busy=%b want 1/0", tag, done, busy);
      end
      checks++;
      @(negedge clk);
      ce = 1'b1;
      #1;
      if (ce_out !== 4'hF) begin
         errors++; $display("FAIL %s_run_ce_out got=%b want=1111", tag, ce_out);
      end
      checks++;
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      ce = 1'b1;
      #2; rst_n = 1'b0;
      #1;
      if ({ce_out, done, fault, busy} !== {4'b0, 1'b0, 1'b0, 1'b1}) begin
         errors++; $display("FAIL async_reset got=%b want=0000001", {ce_out, done, fault, busy});
      end
      checks++;
      test_nominal("rerun");
   endtask

   task automatic test_timeout();
      int s2, fault_s2, wclk;
      logic [3:0] acc;
      logic c;
      do_reset();
      s2 = 0; fault_s2 = -1; wclk = 0; acc = '0;
      for (int i = 0; i < 3000 && fault_s2 < 0; i++) begin
         @(negedge clk);
         c = ($urandom_range(0, 3) != 0);
         if (m.waiting) wclk++; else wclk = 0;
         if (m.waiting && wclk >= 3 && m.n_en <= 2) acc[m.n_en-1] = 1'b1;
         if (c && m.waiting && m.n_en == 3) s2++;
         ce = c; ack = acc;
         #1;
         if (outs() !== exp_outs(m, c)) begin
            errors++; $display("FAIL timeout cyc=%0d got=%h want=%h", i, outs(), exp_outs(m, c));
         end
         checks++;
         if (fault === 1'b1) fault_s2 = s2;
      end
      if (fault_s2 != 64) begin
         errors++; $display("FAIL timeout_len ce_hi_in_ack=%0d want=64", fault_s2);
      end
      checks++;
      // The fault latches: ACK noise and CE activity must not disturb it.
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         ce = 1'b1; ack = 4'($urandom);
         #1;
         if ({ce_out, fault, fault_stage, busy, done} !== {4'b0, 1'b1, 4'd2, 1'b0, 1'b0}) begin
            errors++; $display("FAIL fault_hold cyc=%0d got=%b want=00001001000", i, {ce_out, fault, fault_stage, busy, done});
         end
         checks++;
      end
   endtask

   task automatic test_restart_fault();
      @(negedge clk);
      ce = 1'b1; restart = 1'b1; ack = '0;
      @(negedge clk);
      restart = 1'b0;
      #1;
      if ({fault, busy, fault_stage, ce_out} !== {1'b0, 1'b1, 4'd0, 4'd0}) begin
         errors++; $display("FAIL restart_fault got=%b want=0100000000", {fault, busy, fault_stage, ce_out});
      end
      checks++;
   endtask

   task automatic test_race();
      int wclk;
      logic [3:0] acc;
      bit raced;
      logic [3:0] want;
      do_reset();
      wclk = 0; acc = '0; raced = 1'b0;
      for (int i = 0; i < 500 && !raced; i++) begin
         @(negedge clk);
         if (m.waiting) wclk++; else wclk = 0;
         if (m.waiting && m.n_en == 1 && wclk >= 3) acc[0] = 1'b1;
         // ACK stage 1 in its 64th CE-high cycle of waiting, the same edge the timeout would fire on.
         if (m.waiting && m.n_en == 2 && m.cnt == 63) begin
            acc[1] = 1'b1; raced = 1'b1;
         end
         ce = 1'b1; ack = acc;
         #1;
         if (outs() !== exp_outs(m, ce)) begin
            errors++; $display("FAIL race cyc=%0d got=%h want=%h", i, outs(), exp_outs(m, ce));
         end
         checks++;
      end
      for (int j = 1; j <= 17; j++) begin
         @(negedge clk);
         ce = 1'b1;
         #1;
         want = (j == 17) ? 4'b0111 : 4'b0011;
         if (!(raced && fault === 1'b0 && ce_out === want)) begin
            errors++; $display("FAIL race_proceed j=%0d raced=%0d fault=%b got=%b want=%b", j, raced, fault, ce_out, want);
         end
         checks++;
      end
   endtask

   task automatic test_restart_mid();
      int wclk, ce_hi, first_hi;
      logic [3:0] acc;
      bit hit;
      logic r;
      do_reset();
      wclk = 0; acc = '0; hit = 1'b0;
      for (int i = 0; i < 400 && !hit; i++) begin
         @(negedge clk);
         if (m.waiting) wclk++; else wclk = 0;
         if (m.waiting && wclk >= 3) acc[m.n_en-1] = 1'b1;
         r = (!m.waiting && !m.run && !m.flt && m.n_en == 2 && m.cnt == 7);
         ce = 1'b1; restart = r; ack = acc;
         #1;
         if (outs() !== exp_outs(m, ce)) begin
            errors++; $display("FAIL restart_mid cyc=%0d got=%h want=%h", i, outs(), exp_outs(m, ce));
         end
         checks++;
         hit = r;
      end
      @(negedge clk);
      ce = 1'b1; restart = 1'b0; ack = '0;
      #1;
      if (!(hit && ce_out === 4'b0 && busy === 1'b1)) begin
         errors++; $display("FAIL restart_clear hit=%0d ce_out=%b busy=%b want 1/0000/1", hit, ce_out, busy);
      end
      checks++;
      ce_hi = 1; first_hi = 0;
      for (int i = 0; i < 60 && first_hi == 0; i++) begin
         @(negedge clk);
         ce = 1'b1;
         ce_hi++;
         #1;
         if (ce_out[0] === 1'b1) first_hi = ce_hi;
      end
      if (first_hi != 17) begin
         errors++; $display("FAIL restart_en0_rise first_ce_out_cycle=%0d want=17", first_hi);
      end
      checks++;
      // RESTART held high keeps the counter pinned at zero. Counting resumes cleanly afterwards.
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         ce = 1'($urandom_range(0, 1)); restart = (i < 5); ack = '0;
         #1;
         if (outs() !== exp_outs(m, ce)) begin
            errors++; $display("FAIL restart_hold cyc=%0d got=%h want=%h", i, outs(), exp_outs(m, ce));
         end
         checks++;
      end
      restart = 1'b0;
   endtask

   task automatic test_random();
      int dly [4];
      int wclk;
      logic [3:0] acc, noise;
      logic c, r;
      for (int run_i = 0; run_i < 4; run_i++) begin
         do_reset();
         foreach (dly[k]) dly[k] = $urandom_range(0, 90);
         acc = '0; wclk = 0;
         for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            c = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 149) == 0);
            if (m.waiting) wclk++; else wclk = 0;
            if (m.waiting && wclk > dly[m.n_en-1]) acc[m.n_en-1] = 1'b1;
            noise = 4'($urandom);
            if (m.waiting) noise[m.n_en-1] = 1'b0;
            if (r) acc = '0;
            ce = c; restart = r; ack = acc | noise;
            #1;
            if (outs() !== exp_outs(m, c)) begin
               errors++; $display("FAIL random run=%0d cyc=%0d got=%h want=%h", run_i, i, outs(), exp_outs(m, c));
            end
            checks++;
         end
      end
      restart = 1'b0;
   endtask

   initial begin
      test_reset();
      test_delay0();
      test_nominal("nominal");
      test_async_reset();
      test_timeout();
      test_restart_fault();
      test_race();
      test_restart_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
